// File: rtl/im_pkg.sv
// Shared definitions for the instruction and data memories: reset PC,
// default depth, word type and big-endian byte-lane assembly.
package im_pkg;

  localparam logic [15:0] CODE_SEG_PC = 16'h3000;
  localparam int          IM_DEPTH    = 32768;

  typedef logic [31:0] word_t;

  // b0 is the byte at the lowest address and lands in the most significant lane.
  function automatic word_t be_word(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/im_32k_mem.sv
// Byte-addressed big-endian instruction memory with a combinational read
// port and a sticky misaligned-fetch flag; IM_WRITE_PORT_EN adds a write port.
module im_32k_mem
  import im_pkg::*;
#(
  parameter int DEPTH = IM_DEPTH,
  parameter int AW    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  output logic [31:0] dout,
  output logic        misaligned
`ifdef IM_WRITE_PORT_EN
  ,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [31:0] wdata
`endif
);

  // Name and byte indexing are relied upon by hierarchical hex-image preloads.
  reg [7:0] im [0:DEPTH-1];

  logic [AW-1:0] ra0, ra1, ra2, ra3;
  logic [AW-1:0] wa0, wa1, wa2, wa3;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  word_t         wr_data;

  // Upper address bits alias; AW-bit arithmetic wraps byte offsets at DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr[15:AW]};

  assign ra0 = addr[AW-1:0];
  assign ra1 = ra0 + AW'(1);
  assign ra2 = ra0 + AW'(2);
  assign ra3 = ra0 + AW'(3);

  always_comb begin
    dout = be_word(im[ra0], im[ra1], im[ra2], im[ra3]);
  end

`ifdef IM_WRITE_PORT_EN
  logic unused_waddr_hi;
  assign unused_waddr_hi = &{1'b0, waddr[15:AW]};
  assign wr_en   = we;
  assign wr_addr = waddr[AW-1:0];
  assign wr_data = wdata;
`else
  assign wr_en   = 1'b0;
  assign wr_addr = '0;
  assign wr_data = '0;
`endif

  assign wa0 = wr_addr;
  assign wa1 = wr_addr + AW'(1);
  assign wa2 = wr_addr + AW'(2);
  assign wa3 = wr_addr + AW'(3);

  // NOTE: storage has no reset branch, so preloaded images survive rst_n and
  // the array maps onto plain RAM rather than thousands of resettable flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      im[wa0] <= wr_data[31:24];
      im[wa1] <= wr_data[23:16];
      im[wa2] <= wr_data[15:8];
      im[wa3] <= wr_data[7:0];
    end
  end

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
    end else if (addr[1:0] != 2'b00) begin
      misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_im_32k_mem.sv
// Scoreboard bench for im_32k_mem: a driver pushes expected words/flags,
// a negedge monitor pops and compares against the DUT outputs.
module tb_im_32k_mem;
  import im_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] addr  = CODE_SEG_PC;
  word_t       dout;
  logic        misaligned;
  logic        we    = 1'b0;
  logic [15:0] waddr = '0;
  word_t       wdata = '0;
  bit          clk_en = 1'b0;

  im_32k_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .dout      (dout),
    .misaligned(misaligned)
`ifdef IM_WRITE_PORT_EN
    ,
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
`endif
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    word_t       d;
    logic        m;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [0:IM_DEPTH-1];
  int          errors = 0;
  int          checks = 0;

  logic [15:0] cur_addr  = CODE_SEG_PC;
  logic        cur_we    = 1'b0;
  logic [15:0] cur_waddr = '0;
  word_t       cur_wdata = '0;
  bit          ref_mis   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic word_t ref_rd(input logic [15:0] a);
    int b = int'(a) % IM_DEPTH;
    return {ref_mem[b], ref_mem[(b + 1) % IM_DEPTH],
            ref_mem[(b + 2) % IM_DEPTH], ref_mem[(b + 3) % IM_DEPTH]};
  endfunction

  task automatic poke(input int adr, input logic [7:0] v);
    ref_mem[adr] = v;
    dut.im[adr]  = v;
  endtask

  // Advance one edge (updating the model with what the DUT sampled there),
  // then apply new inputs and queue the expected response.
  task automatic step(input logic [15:0] a, input logic w, input logic [15:0] wa,
                      input word_t wd, input bit use_c, input word_t c);
    exp_t e;
    @(posedge clk);
    if (cur_addr[1:0] != 2'b00) ref_mis = 1'b1;
    if (cur_we) begin
      for (int k = 0; k < 4; k++)
        ref_mem[(int'(cur_waddr) + k) % IM_DEPTH] = cur_wdata[31 - 8*k -: 8];
    end
    #1;
    addr = a; we = w; waddr = wa; wdata = wd;
    cur_addr = a; cur_we = w; cur_waddr = wa; cur_wdata = wd;
    e.a = a;
    e.d = use_c ? c : ref_rd(a);
    e.m = ref_mis;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check($sformatf("dout@%h", mon_e.a), dout, mon_e.d);
      check($sformatf("misaligned@%h", mon_e.a), {31'b0, misaligned}, {31'b0, mon_e.m});
    end
  end

  initial begin
    for (int i = 0; i < IM_DEPTH; i++) poke(i, 8'($urandom));
    for (int i = 0; i < 256; i++) poke(int'(CODE_SEG_PC) + i, 8'(i));
    poke(16'h7FFD, 8'hAA);
    poke(16'h7FFE, 8'hBB);
    poke(16'h7FFF, 8'hCC);
    poke(16'h0000, 8'hDD);

    #1 rst_n = 1'b0;
    #1 check("reset_flag", {31'b0, misaligned}, 32'd0);
    #2 rst_n = 1'b1;
    clk_en = 1'b1;

    for (int k = 0; k < 10; k++)
      step(CODE_SEG_PC + 16'(4*k), 1'b0, '0, '0, 1'b1,
           word_t'(32'h00010203 + k * 32'h04040404));
    step(16'h3001, 1'b0, '0, '0, 1'b1, 32'h01020304);
    step(16'h3000, 1'b0, '0, '0, 1'b1, 32'h00010203);
    step(16'hFFFD, 1'b0, '0, '0, 1'b1, 32'hAABBCCDD);
    step(16'h3000, 1'b0, '0, '0, 1'b1, 32'h00010203);
    drain();

    // Reset with the clock stopped: flag clears, contents remain.
    clk_en = 1'b0;
    #20 rst_n = 1'b0;
    #1 check("async_reset_flag", {31'b0, misaligned}, 32'd0);
    addr = CODE_SEG_PC;
    #1 check("dout_in_reset", dout, 32'h00010203);
    #10 rst_n = 1'b1;
    cur_addr = CODE_SEG_PC;
    cur_we   = 1'b0;
    ref_mis  = 1'b0;
    #3 clk_en = 1'b1;

`ifdef IM_WRITE_PORT_EN
    step(16'h3000, 1'b1, 16'h3000, 32'hDEADBEEF, 1'b1, 32'h00010203);
    step(16'h3000, 1'b0, '0, '0, 1'b1, 32'hDEADBEEF);
    step(16'h3004, 1'b0, '0, '0, 1'b1, 32'h04050607);
`endif

    for (int n = 0; n < 300; n++) begin
      logic        w  = 1'b0;
      logic [15:0] a  = 16'($urandom);
      logic [15:0] wa = 16'($urandom);
      word_t       wd = $urandom;
      // Mostly aligned fetches early on so the flag's first set is exercised.
      if (n < 40) a[1:0] = (n == 25) ? 2'b10 : 2'b00;
`ifdef IM_WRITE_PORT_EN
      w = ($urandom_range(0, 3) == 0);
      if (w && $urandom_range(0, 1) == 1) wa = a;
`endif
      step(a, w, wa, wd, 1'b0, '0);
    end
    drain();

    // Reset pulsed between edges with the clock running.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midcycle_reset_flag", {31'b0, misaligned}, 32'd0);
    #1 rst_n = 1'b1;
    ref_mis = 1'b0;
    step(16'h3000, 1'b0, '0, '0, 1'b0, '0);
    step(16'h3002, 1'b0, '0, '0, 1'b0, '0);
    step(16'h3004, 1'b0, '0, '0, 1'b0, '0);
    step(16'h3008, 1'b0, '0, '0, 1'b0, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
